// File: rtl/crc5_token_sched.sv
// Round-robin sequencer for the shared CRC5 engine: grants the TX token
// builder or the RX token checker, feeds the 11 token bits, returns the result.
module crc5_token_sched #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       txReq,
  input  logic [6:0] txAddr,
  input  logic [3:0] txEndp,
  output logic       txGnt,
  output logic       txDone,
  output logic [4:0] txCRC5,
  input  logic       rxReq,
  input  logic [6:0] rxAddr,
  input  logic [3:0] rxEndp,
  input  logic [4:0] rxCRC5In,
  output logic       rxGnt,
  output logic       rxDone,
  output logic       rxCRCOk,
  output logic       opErr,
  output logic       rstCRC,
  output logic       CRCEn,
  output logic       CRC5_8BitIn,
  output logic [7:0] dataOut,
  input  logic [4:0] CRCResult,
  input  logic       ready
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_BYTE  = 3'd2;
  localparam logic [2:0] S_WAITB = 3'd3;
  localparam logic [2:0] S_BITS  = 3'd4;
  localparam logic [2:0] S_WAITR = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [2:0]    state;
  logic          is_rx;
  logic          contested;
  logic          prio_tx;
  logic [6:0]    addr_q;
  logic [3:0]    endp_q;
  logic [4:0]    crc_q;
  logic [CW-1:0] wait_cnt;

  logic pick_rx;
  logic wait_ready;
  logic wait_expired;

  // The first wait cycle ignores ready: the engine only drops it one cycle after CRCEn.
  always_comb begin
    pick_rx      = rxReq && (!txReq || !prio_tx);
    wait_ready   = (wait_cnt != '0) && ready;
    wait_expired = (wait_cnt == CW'(TIMEOUT - 1));
  end

  // NOTE: every register here is assigned with <= so all outputs update together
  // on the edge; blocking assignments would make results depend on statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      is_rx       <= 1'b0;
      contested   <= 1'b0;
      prio_tx     <= 1'b1;
      addr_q      <= '0;
      endp_q      <= '0;
      crc_q       <= '0;
      wait_cnt    <= '0;
      txGnt       <= 1'b0;
      txDone      <= 1'b0;
      txCRC5      <= '0;
      rxGnt       <= 1'b0;
      rxDone      <= 1'b0;
      rxCRCOk     <= 1'b0;
      opErr       <= 1'b0;
      rstCRC      <= 1'b1;
      CRCEn       <= 1'b0;
      CRC5_8BitIn <= 1'b0;
      dataOut     <= '0;
    end else begin
      txDone      <= 1'b0;
      rxDone      <= 1'b0;
      rstCRC      <= 1'b0;
      CRCEn       <= 1'b0;
      CRC5_8BitIn <= 1'b0;
      dataOut     <= '0;

      case (state)
        S_IDLE: begin
          if (txReq || rxReq) begin
            is_rx     <= pick_rx;
            contested <= txReq && rxReq;
            addr_q    <= pick_rx ? rxAddr : txAddr;
            endp_q    <= pick_rx ? rxEndp : txEndp;
            crc_q     <= rxCRC5In;
            txGnt     <= !pick_rx;
            rxGnt     <= pick_rx;
            opErr     <= 1'b0;
            rstCRC    <= 1'b1;
            state     <= S_CLR;
          end
        end

        S_CLR: begin
          CRCEn       <= 1'b1;
          CRC5_8BitIn <= 1'b1;
          dataOut     <= {endp_q[0], addr_q};
          state       <= S_BYTE;
        end

        S_BYTE, S_BITS: begin
          wait_cnt <= '0;
          state    <= (state == S_BYTE) ? S_WAITB : S_WAITR;
        end

        S_WAITB, S_WAITR: begin
          if (wait_ready && state == S_WAITB) begin
            CRCEn   <= 1'b1;
            dataOut <= {5'b0, endp_q[3:1]};
            state   <= S_BITS;
          end else if (wait_ready || wait_expired) begin
            // Ready wins over an expiry landing on the same cycle.
            txDone <= !is_rx;
            rxDone <= is_rx;
            if (!is_rx) txCRC5 <= wait_ready ? ~CRCResult : 5'h00;
            else        rxCRCOk <= wait_ready && (~CRCResult == crc_q);
            opErr  <= !wait_ready;
            rstCRC <= !wait_ready;
            txGnt  <= 1'b0;
            rxGnt  <= 1'b0;
            // Fairness only shifts when both requesters competed for this grant.
            if (contested) prio_tx <= is_rx;
            state  <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc5_token_sched.sv
// Randomized bench for crc5_token_sched: CRC5 engine model, USB CRC5 reference,
// and a scoreboard checked by a monitor on every done pulse.
module tb_crc5_token_sched;

  localparam int TIMEOUT = 15;
  localparam int LAT_OK  = 16;
  localparam int LAT_TO  = 2 + TIMEOUT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       txReq = 1'b0, rxReq = 1'b0;
  logic [6:0] txAddr = '0, rxAddr = '0;
  logic [3:0] txEndp = '0, rxEndp = '0;
  logic [4:0] rxCRC5In = '0;
  logic       txGnt, txDone, rxGnt, rxDone, rxCRCOk, opErr;
  logic       rstCRC, CRCEn, CRC5_8BitIn, ready;
  logic [4:0] txCRC5, CRCResult;
  logic [7:0] dataOut;

  always #5 clk = ~clk;

  crc5_token_sched #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .txReq(txReq), .txAddr(txAddr), .txEndp(txEndp),
    .txGnt(txGnt), .txDone(txDone), .txCRC5(txCRC5),
    .rxReq(rxReq), .rxAddr(rxAddr), .rxEndp(rxEndp), .rxCRC5In(rxCRC5In),
    .rxGnt(rxGnt), .rxDone(rxDone), .rxCRCOk(rxCRCOk), .opErr(opErr),
    .rstCRC(rstCRC), .CRCEn(CRCEn), .CRC5_8BitIn(CRC5_8BitIn),
    .dataOut(dataOut), .CRCResult(CRCResult), .ready(ready)
  );

  // ---------------- CRC5 engine model (reflected shift register) ----------------
  int         busy;
  bit         stuck = 1'b0;
  logic [4:0] eng_crc;

  function automatic logic [4:0] eng_step(input logic [4:0] c, input logic [7:0] d, input int n);
    logic fb;
    for (int i = 0; i < n; i++) begin
      fb = c[0] ^ d[i];
      c  = c >> 1;
      if (fb) c = c ^ 5'h14;
    end
    return c;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst)       busy <= 0;
    else if (CRCEn) busy <= CRC5_8BitIn ? 8 : 3;
    else if (busy > 0) busy <= busy - 1;
  end

  always @(posedge clk) begin
    if (rstCRC)     eng_crc <= 5'h1f;
    else if (CRCEn) eng_crc <= eng_step(eng_crc, dataOut, CRC5_8BitIn ? 8 : 3);
  end

  assign ready     = !stuck && (busy == 0);
  assign CRCResult = eng_crc;

  // ---------------- reference model: USB CRC5 over the 11-bit token ----------------
  function automatic logic [4:0] ref_crc5(input logic [6:0] a, input logic [3:0] ep);
    logic [10:0] tok;
    logic [4:0]  r, res;
    logic        fb;
    tok = {ep, a};
    r   = 5'h1f;
    for (int i = 0; i < 11; i++) begin
      fb = r[4] ^ tok[i];
      r  = {r[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
    end
    for (int j = 0; j < 5; j++) res[j] = ~r[4 - j];
    return res;
  endfunction

  typedef struct {
    bit         is_rx;
    logic [4:0] crc;
    bit         ok;
    bit         err;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  bit   prio_tx = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk_tx(input logic [6:0] a, input logic [3:0] ep, input bit err);
    exp_t e;
    e.is_rx = 1'b0;
    e.crc   = err ? 5'h00 : ref_crc5(a, ep);
    e.ok    = 1'b0;
    e.err   = err;
    e.lat   = err ? LAT_TO : LAT_OK;
    return e;
  endfunction

  function automatic exp_t mk_rx(input logic [6:0] a, input logic [3:0] ep, input logic [4:0] cin, input bit err);
    exp_t e;
    e.is_rx = 1'b1;
    e.crc   = 5'h00;
    e.ok    = !err && (ref_crc5(a, ep) == cin);
    e.err   = err;
    e.lat   = err ? LAT_TO : LAT_OK;
    return e;
  endfunction

  // ---------------- monitor ----------------
  int         cyc = 0;
  int         start_cyc = 0;
  int         en_cnt = 0;
  logic [1:0] en_rec = '0;
  bit         prev_tx = 1'b0, prev_rx = 1'b0, overlap = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst) begin
      prev_tx = 1'b0;
      prev_rx = 1'b0;
      en_cnt  = 0;
      en_rec  = '0;
    end else begin
      if (txGnt && rxGnt) overlap = 1'b1;
      if ((txGnt && !prev_tx) || (rxGnt && !prev_rx)) begin
        start_cyc = cyc;
        en_cnt    = 0;
        en_rec    = '0;
      end
      if (CRCEn) begin
        en_cnt++;
        en_rec = {en_rec[0], CRC5_8BitIn};
      end
      if (txDone || rxDone) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("done_kind", rxDone, e.is_rx);
          if (e.is_rx) check("rx_crc_ok", rxCRCOk, e.ok);
          else         check("tx_crc5", txCRC5, e.crc);
          check("op_err", opErr, e.err);
          check("latency", cyc - start_cyc, e.lat);
          check("crc_en_count", en_cnt, e.err ? 1 : 2);
          check("crc_en_8bit_pattern", en_rec, e.err ? 2'b01 : 2'b10);
        end
      end
      prev_tx = txGnt;
      prev_rx = rxGnt;
    end
  end

  // ---------------- stimulus ----------------
  task automatic check_reset_outputs(input string name);
    check(name, {txGnt, txDone, txCRC5, rxGnt, rxDone, rxCRCOk, opErr,
                 rstCRC, CRCEn, CRC5_8BitIn, dataOut}, 22'h000400);
  endtask

  task automatic run_op(input bit rx, input logic [6:0] a, input logic [3:0] ep,
                        input logic [4:0] cin, input exp_t e, input bit drop);
    bit got = 1'b0;
    @(negedge clk);
    if (rx) begin rxAddr = a; rxEndp = ep; rxCRC5In = cin; rxReq = 1'b1; end
    else    begin txAddr = a; txEndp = ep; txReq = 1'b1; end
    sb.push_back(e);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rx ? rxDone : txDone) begin got = 1'b1; break; end
      if (txGnt || rxGnt) begin
        txAddr = 7'($urandom); txEndp = 4'($urandom);
        rxAddr = 7'($urandom); rxEndp = 4'($urandom); rxCRC5In = 5'($urandom);
        if (drop) begin txReq = 1'b0; rxReq = 1'b0; end
      end
    end
    txReq = 1'b0;
    rxReq = 1'b0;
    if (!got) check("op_done_bound", 0, 1);
  endtask

  task automatic run_pair(input logic [6:0] ta, input logic [3:0] te,
                          input logic [6:0] ra, input logic [3:0] re, input logic [4:0] rc);
    bit td = 1'b0, rd = 1'b0;
    @(negedge clk);
    txAddr = ta; txEndp = te; txReq = 1'b1;
    rxAddr = ra; rxEndp = re; rxCRC5In = rc; rxReq = 1'b1;
    if (prio_tx) begin sb.push_back(mk_tx(ta, te, 1'b0)); sb.push_back(mk_rx(ra, re, rc, 1'b0)); end
    else         begin sb.push_back(mk_rx(ra, re, rc, 1'b0)); sb.push_back(mk_tx(ta, te, 1'b0)); end
    prio_tx = !prio_tx;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (txDone) begin td = 1'b1; txReq = 1'b0; end
      if (rxDone) begin rd = 1'b1; rxReq = 1'b0; end
      if (td && rd) break;
    end
    txReq = 1'b0;
    rxReq = 1'b0;
    if (!(td && rd)) check("pair_done_bound", 0, 1);
  endtask

  initial begin
    exp_t       e;
    logic [6:0] a;
    logic [3:0] ep;
    logic [4:0] c;

    #3 rst = 1'b0;
    #1 check_reset_outputs("reset_outputs");
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Directed all-zero token: known CRC5 is 5'h02.
    e = mk_tx(7'h00, 4'h0, 1'b0);
    e.crc = 5'h02;
    run_op(1'b0, 7'h00, 4'h0, 5'h00, e, 1'b0);
    e = mk_rx(7'h00, 4'h0, 5'h02, 1'b0);
    e.ok = 1'b1;
    run_op(1'b1, 7'h00, 4'h0, 5'h02, e, 1'b0);
    e.ok = 1'b0;
    run_op(1'b1, 7'h00, 4'h0, 5'h03, e, 1'b0);

    // Simultaneous requests: TX first after reset, then RX wins the next contest.
    run_pair(7'h15, 4'he, 7'h3a, 4'h7, ref_crc5(7'h3a, 4'h7));
    run_pair(7'h7f, 4'hf, 7'h01, 4'h1, 5'h1f);

    // Engine never becomes ready: aborted ops, then a clean one.
    stuck = 1'b1;
    run_op(1'b1, 7'h12, 4'h3, ref_crc5(7'h12, 4'h3), mk_rx(7'h12, 4'h3, 5'h00, 1'b1), 1'b0);
    run_op(1'b0, 7'h55, 4'h9, 5'h00, mk_tx(7'h55, 4'h9, 1'b1), 1'b0);
    stuck = 1'b0;
    run_op(1'b0, 7'h55, 4'h9, 5'h00, mk_tx(7'h55, 4'h9, 1'b0), 1'b0);

    // Reset in the middle of WAITB: no done pulse, then a normal op.
    @(negedge clk);
    txAddr = 7'h2c; txEndp = 4'h5; txReq = 1'b1;
    for (int i = 0; i < 10 && !txGnt; i++) @(negedge clk);
    check("midop_gnt_seen", txGnt, 1'b1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1 check_reset_outputs("midop_reset_outputs");
    txReq = 1'b0;
    prio_tx = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_op(1'b0, 7'h2c, 4'h5, 5'h00, mk_tx(7'h2c, 4'h5, 1'b0), 1'b0);

    // Random TX ops, some dropping the request mid-operation.
    for (int n = 0; n < 200; n++) begin
      a  = 7'($urandom);
      ep = 4'($urandom);
      run_op(1'b0, a, ep, 5'h00, mk_tx(a, ep, 1'b0), ($urandom_range(0, 7) == 0));
    end

    // Random RX ops, roughly half with a corrupted CRC field.
    for (int n = 0; n < 40; n++) begin
      a  = 7'($urandom);
      ep = 4'($urandom);
      c  = ref_crc5(a, ep) ^ (($urandom_range(0, 1) == 1) ? 5'(1 << $urandom_range(0, 4)) : 5'h00);
      run_op(1'b1, a, ep, c, mk_rx(a, ep, c, 1'b0), 1'b0);
    end

    repeat (5) @(negedge clk);
    check("grant_overlap", overlap, 1'b0);
    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/crc5_token_sched.md
Name: crc5_token_sched

Overview:
- Sequencer and arbiter for the shared CRC5 update engine in the serial interface engine.
- Two requesters use it: the TX token builder, which needs a CRC5 generated, and the RX token checker, which needs a received CRC5 verified.
- The block grants one requester at a time, clears the engine, and feeds the 11 token bits as one 8-bit update followed by one 3-bit update.
- It waits on the engine's ready signal, then returns the CRC or a match flag, with a done pulse.

Parameters:
- TIMEOUT, 15, maximum cycles spent waiting for engine ready per update before the operation is aborted.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- txReq  input  1  TX requests CRC5 generation; held until txDone
- txAddr  input  7  TX token address
- txEndp  input  4  TX token endpoint
- txGnt  output  1  TX operation in progress
- txDone  output  1  one-cycle pulse; txCRC5 valid
- txCRC5  output  5  inverted CRC5, ready to transmit
- rxReq  input  1  RX requests CRC5 check; held until rxDone
- rxAddr  input  7  received address
- rxEndp  input  4  received endpoint
- rxCRC5In  input  5  received CRC5 field, same representation as txCRC5
- rxGnt  output  1  RX operation in progress
- rxDone  output  1  one-cycle pulse; rxCRCOk valid
- rxCRCOk  output  1  received CRC matches computed CRC
- opErr  output  1  sticky for last op: 1 if aborted by timeout; valid with done
- rstCRC  output  1  engine clear
- CRCEn  output  1  engine update strobe
- CRC5_8BitIn  output  1  1 = 8-bit update, 0 = 3-bit update
- dataOut  output  8  engine data, LSB shifted first
- CRCResult  input  5  engine running CRC
- ready  input  1  engine idle

Behaviour:
- Reset (rst=0, async), all outputs as follows:
  - state=IDLE, rstCRC=1, all other outputs 0.
  - Round-robin pointer is set to favour TX.
- States: IDLE, CLR, BYTE, WAITB, BITS, WAITR, DONE. All outputs are registered.
- IDLE:
  - If exactly one request is high, grant it.
  - If both are high, grant the requester not granted last (round robin; TX first after reset).
  - Capture addr, endp and (for RX) rxCRC5In into internal registers. Go to CLR. The matching Gnt goes high and is held through DONE.
- CLR: rstCRC=1 for one cycle. Go to BYTE.
- BYTE: CRCEn=1, CRC5_8BitIn=1, dataOut={endp[0],addr[6:0]}. Go to WAITB.
- WAITB:
  - The first cycle ignores ready, because the engine drops ready one cycle after CRCEn.
  - After that, go to BITS on ready=1.
- BITS: CRCEn=1, CRC5_8BitIn=0, dataOut={5'b0,endp[3:1]}. Go to WAITR.
- WAITR: same rule as WAITB. Go to DONE on ready=1.
- DONE, one cycle:
  - TX: txCRC5 = ~CRCResult, txDone=1.
  - RX: rxCRCOk = (~CRCResult == captured rxCRC5In), rxDone=1.
  - Gnt is deasserted, the round-robin pointer is updated, and the next state is IDLE.
- Outside DONE:
  - txCRC5 and rxCRCOk hold their last values.
  - CRCEn and rstCRC are 0 except in their own states.
  - dataOut is 0 except in BYTE and BITS.
- Timeout: a wait counter counts cycles in WAITB/WAITR.
  - When it reaches TIMEOUT: opErr=1, rstCRC=1, go to DONE.
  - The done pulse is still given: rxCRCOk=0, txCRC5=5'h00.
  - opErr is cleared on the next grant.
- Latency: with a conforming engine (ready low for 8 and 3 cycles respectively), Done asserts exactly 16 cycles after the first cycle Gnt is high.
- Requests are sampled only in IDLE.
  - A request dropped mid-operation does not abort; Done is still pulsed.
  - A request held after Done is treated as a new request in IDLE.
- Reset asserted mid-operation: immediate return to IDLE, no Done pulse.

Test Plan:
- TX addr=7'h00, endp=4'h0 -> txDone 16 cycles after txGnt rises; txCRC5=5'h02, opErr=0.
- RX addr=7'h00, endp=4'h0 with rxCRC5In=5'h02 -> rxCRCOk=1; with rxCRC5In=5'h03 -> rxCRCOk=0.
- txReq and rxReq high in the same IDLE cycle after reset, both held -> TX served first, then RX; grants never overlap; next simultaneous pair serves RX first.
- Engine model holds ready=0 forever -> Done pulse after TIMEOUT cycles in WAITB with opErr=1 and rxCRCOk=0; the next op succeeds with opErr=0.
- rst pulled low during WAITB -> all outputs go to reset values asynchronously; no Done pulse; a new request after release completes normally.
- Random addr/endp, 200 TX ops -> txCRC5 matches the USB CRC5 reference model; CRCEn pulses exactly twice per op, with CRC5_8BitIn pattern 1 then 0.
